// File: rtl/zigzag_descan_buffer_if.sv
// AXI-stream style handshake bundle: one payload word plus valid/ready/last.
// A single width parameter serves both the coefficient side and the row side.
interface zigzag_descan_buffer_if #(
    parameter int W = 12
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/zigzag_descan_buffer.sv
// Ping-pong 8x8 de-zigzag buffer: coefficients arrive one per beat in scan order
// and leave as raster rows of eight, column 0 in the top slice.
module zigzag_descan_buffer #(
    parameter int WIN = 12
) (
    input  logic                    clock,
    input  logic                    reset_n,
    zigzag_descan_buffer_if.slave   slave,
    zigzag_descan_buffer_if.master  master,
    output logic                    len_err
);

    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [1:0][63:0][WIN-1:0] bank_q;
    logic [1:0] full_q,    full_d;
    logic       wr_bank_q, wr_bank_d;
    logic [5:0] wr_cnt_q,  wr_cnt_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] rd_row_q,  rd_row_d;
    logic       len_err_q, len_err_d;

    logic           s_hs, m_hs, wr_close, rd_close;
    logic [5:0]     wr_addr;
    logic [8*WIN-1:0] row_sel;

    assign slave.tready  = ~full_q[wr_bank_q];
    assign master.tvalid = full_q[rd_bank_q];
    assign master.tlast  = full_q[rd_bank_q] & (rd_row_q == 3'd7);
    assign master.tdata  = full_q[rd_bank_q] ? row_sel : '0;
    assign len_err       = len_err_q;

    assign s_hs     = slave.tvalid & ~full_q[wr_bank_q];
    assign m_hs     = full_q[rd_bank_q] & master.tready;
    assign wr_close = s_hs & (slave.tlast | (wr_cnt_q == 6'd63));
    assign rd_close = m_hs & (rd_row_q == 3'd7);
    assign wr_addr  = 6'(ZZ[wr_cnt_q]);

    always_comb begin
        row_sel = '0;
        for (int c = 0; c < 8; c++)
            row_sel[(7-c)*WIN +: WIN] = bank_q[rd_bank_q][{rd_row_q, 3'(c)}];
    end

    // A closing write and a releasing read always target different banks,
    // so both full-flag updates can land on the same edge.
    always_comb begin
        full_d    = full_q;
        if (rd_close) full_d[rd_bank_q] = 1'b0;
        if (wr_close) full_d[wr_bank_q] = 1'b1;
        wr_bank_d = wr_bank_q ^ wr_close;
        wr_cnt_d  = wr_close ? 6'd0 : (s_hs ? wr_cnt_q + 6'd1 : wr_cnt_q);
        rd_bank_d = rd_bank_q ^ rd_close;
        rd_row_d  = m_hs ? rd_row_q + 3'd1 : rd_row_q;
        len_err_d = len_err_q | (s_hs & (wr_cnt_q == 6'd63) & ~slave.tlast);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_row_q  <= '0;
            len_err_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_row_q  <= rd_row_d;
            len_err_q <= len_err_d;
        end
    end

    // Released banks are wiped so short blocks read back zeros in unwritten slots.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_q <= '0;
        end else begin
            if (rd_close) bank_q[rd_bank_q] <= '0;
            if (s_hs)     bank_q[wr_bank_q][wr_addr] <= slave.tdata;
        end
    end

endmodule
